imem_read_arbiter: RTL
======================

# imem_read_arbiter

Shares the single-port, synchronous-read instruction memory between two requesters: the core fetch port (F) and the debug/loader read port (D). It arbitrates round-robin and drives the memory address. It tracks the one-cycle read latency and routes returned words to the owning requester, with a holding register for response back-pressure. It sits between the fetch stage / debug unit and the instruction memory instance, and sustains one read per cycle when consumers are ready.

## Interface
- DATA_WIDTH, 32, instruction word width
- MEM_DEPTH, 1024, memory words; ADDR_WIDTH = $clog2(MEM_DEPTH) (derived, word address)
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- f_req_valid  in  1  fetch read request
- f_req_addr  in  ADDR_WIDTH  fetch word address
- f_req_ready  out  1  fetch request accepted this cycle
- f_rsp_valid  out  1  fetch read data valid
- f_rsp_data  out  DATA_WIDTH  fetch read data
- f_rsp_ready  in  1  fetch consumer accepts data
- d_req_valid, d_req_addr, d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_ready: same as f_* for the debug port
- mem_addr  out  ADDR_WIDTH  to memory read address (memory registers data on the next edge)
- mem_data  in  DATA_WIDTH  from memory, word for the address presented in the previous cycle

## Operation
- Handshakes are valid/ready. A transfer occurs on the edge where both are high. A requester holds valid and address stable until ready.
- State: `inflight` (1 bit), `hold` (1 bit), `owner` (F/D of the outstanding read), `hold_data` (DATA_WIDTH), `rr_ptr` (priority: F or D).
- Slot free this cycle (`can_accept`):
  - neither inflight nor hold, or
  - inflight and the owner's rsp_ready is 1, or
  - hold and the owner's rsp_ready is 1.
- Grant (combinational):
  - If can_accept and only one req_valid is high, grant it.
  - If both are high, grant the port named by rr_ptr.
  - req_ready is 1 only for the granted port.
- On grant: mem_addr = granted address; next cycle inflight=1, owner=granted; rr_ptr flips to the non-granted port. With no grant, mem_addr = 0 and rr_ptr is unchanged.
- Response, inflight cycle:
  - owner rsp_valid=1, rsp_data=mem_data (bypass).
  - If rsp_ready=0: capture mem_data into hold_data, hold=1, inflight=0.
- Response, hold state: owner rsp_valid=1, rsp_data=hold_data. On rsp_ready, hold clears unless a new grant reloads inflight.
- The non-owner's rsp_valid is 0. Its rsp_data is don't-care, driven to 0.
- Only one read is ever outstanding or held; inflight and hold are never both 1.

## Timing
- Reset values: all req_ready=0, all rsp_valid=0, rsp_data=0, mem_addr=0, inflight=0, hold=0, rr_ptr=F.
- Latency: request accepted in cycle N gives rsp_valid in cycle N+1, when the consumer is ready.
- Throughput: back-to-back grants every cycle while the owner keeps rsp_ready=1.
- Back-pressure:
  - The first stall cycle moves data to hold_data.
  - No new grant while the slot is not free.
  - Data stays stable on rsp_data until accepted.
- Simultaneous release and grant: hold or inflight data is accepted in the same cycle as a new grant. Next cycle the new response is inflight, with no bubble.
- Both requesters continuously valid: grants alternate F, D, F, D starting with F after reset.
- Reset mid-operation clears inflight, hold and rr_ptr at the edge. Any outstanding response is dropped and never presented; rsp_valid=0 from the next cycle.

## Test plan
- Single fetch: after reset, F requests addr 0x010 (memory word 0x00A00093), rsp_ready=1 → f_req_ready=1 in cycle N, f_rsp_valid=1 with 0x00A00093 in N+1, d_rsp_valid=0.
- Streaming: F requests 0x000..0x007 back-to-back with rsp_ready=1 → 8 grants in 8 consecutive cycles, responses in order, one cycle later each.
- Contention: F and D both valid for 6 cycles (F addrs 0x100+, D addrs 0x200+) → grant order F,D,F,D,F,D; each response appears only on its own port.
- Back-pressure: F reads 0x020, f_rsp_ready=0 for 3 cycles while D is valid →
  - f_rsp_data holds the 0x020 word for 4 cycles;
  - no req_ready to either port during the stall;
  - D is granted in the cycle f_rsp_ready rises.
- Reset mid-read: assert reset in the cycle after a grant to 0x030 → no rsp_valid ever for that read; outputs at reset values; the first post-reset contention grants F.

Source files
------------

// File: rtl/imem_read_arbiter.sv
// Round-robin arbiter sharing a synchronous-read instruction memory
// between the fetch port (F) and the debug/loader port (D).
module imem_read_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int MEM_DEPTH  = 1024,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  f_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] f_req_addr_i,
  output logic                  f_req_ready_o,
  output logic                  f_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] f_rsp_data_o,
  input  logic                  f_rsp_ready_i,
  input  logic                  d_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] d_req_addr_i,
  output logic                  d_req_ready_o,
  output logic                  d_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] d_rsp_data_o,
  input  logic                  d_rsp_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_e;

  logic                  inflight_q, inflight_d;
  logic                  hold_q, hold_d;
  port_e                 owner_q, owner_d;
  port_e                 rr_q, rr_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

  logic                  busy;
  logic                  owner_rdy;
  logic                  can_accept;
  logic                  gnt_f;
  logic                  gnt_d;
  logic                  rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_word;

  always_comb begin
    busy       = inflight_q | hold_q;
    owner_rdy  = (owner_q == PORT_D) ? d_rsp_ready_i
                                     : f_rsp_ready_i;
    // Reset masks grants so nothing is accepted and then lost
    can_accept = !reset_i && (!busy || owner_rdy);
    gnt_f      = can_accept && f_req_valid_i &&
                 (!d_req_valid_i || rr_q == PORT_F);
    gnt_d      = can_accept && d_req_valid_i &&
                 (!f_req_valid_i || rr_q == PORT_D);
    rsp_vld    = busy && !reset_i;
    rsp_word   = inflight_q ? mem_data_i : hold_data_q;
  end

  always_comb begin
    f_req_ready_o = gnt_f;
    d_req_ready_o = gnt_d;
    mem_addr_o    = '0;
    if (gnt_f) begin
      mem_addr_o = f_req_addr_i;
    end else if (gnt_d) begin
      mem_addr_o = d_req_addr_i;
    end
    f_rsp_valid_o = rsp_vld && (owner_q == PORT_F);
    d_rsp_valid_o = rsp_vld && (owner_q == PORT_D);
    f_rsp_data_o  = f_rsp_valid_o ? rsp_word : '0;
    d_rsp_data_o  = d_rsp_valid_o ? rsp_word : '0;
  end

  always_comb begin
    inflight_d  = inflight_q;
    hold_d      = hold_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    hold_data_d = hold_data_q;
    if (gnt_f || gnt_d) begin
      inflight_d = 1'b1;
      hold_d     = 1'b0;
      owner_d    = gnt_d ? PORT_D : PORT_F;
      rr_d       = gnt_f ? PORT_D : PORT_F;
    end else if (inflight_q && !owner_rdy) begin
      inflight_d  = 1'b0;
      hold_d      = 1'b1;
      hold_data_d = mem_data_i;
    end else if (busy && owner_rdy) begin
      inflight_d = 1'b0;
      hold_d     = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      inflight_q  <= 1'b0;
      hold_q      <= 1'b0;
      owner_q     <= PORT_F;
      rr_q        <= PORT_F;
      hold_data_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      hold_q      <= hold_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      hold_data_q <= hold_data_d;
    end
  end

endmodule
